cycle_step_ctrl: RTL

- Sequencer directly upstream of the CPU cycle register. Counts beats (T-steps) inside the current machine cycle (FI, SRC, DST, EXC, INT).
- At the last beat it issues exactly one registered Set_* pulse, chosen from the decoded instruction's operand needs, interrupt state and halt.
- Drives Set_FI/Set_SRC/Set_DST/Set_EXC/Set_INT of the cycle register and takes that register's one-hot cycle outputs back as its input.

---
 rtl/cpu_cycle_pkg.sv | 59 +++++
 rtl/cyc_next_sel.sv | 32 +++
 rtl/cycle_step_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_cycle_pkg.sv
// Shared definitions for the CPU machine-cycle sequencer: cycle one-hot bit
// positions, default beat counts, next-cycle encoding (including HALT).
package cpu_cycle_pkg;

  localparam int unsigned CYC_N   = 5;
  localparam int unsigned CYC_FI  = 0;
  localparam int unsigned CYC_DST = 1;
  localparam int unsigned CYC_SRC = 2;
  localparam int unsigned CYC_EXC = 3;
  localparam int unsigned CYC_INT = 4;

  localparam int unsigned DEF_STEPS_FI  = 4;
  localparam int unsigned DEF_STEPS_SRC = 3;
  localparam int unsigned DEF_STEPS_DST = 3;
  localparam int unsigned DEF_STEPS_EXC = 2;
  localparam int unsigned DEF_STEPS_INT = 4;
  localparam int unsigned DEF_CNT_W     = 3;
  localparam int unsigned DEF_WD_LIMIT  = 15;

  typedef logic [CYC_N-1:0] cyc_vec_t;

  // NX_HALT has no cycle-register bit; it parks the sequencer instead.
  typedef enum logic [2:0] {
    NX_FI   = 3'd0,
    NX_DST  = 3'd1,
    NX_SRC  = 3'd2,
    NX_EXC  = 3'd3,
    NX_INT  = 3'd4,
    NX_HALT = 3'd7
  } nxt_cyc_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic need_src;
    logic need_dst;
    logic int_req;
    logic int_en;
    logic halt;
  } sel_ctl_t;

  function automatic cyc_vec_t cyc_set_vec(input nxt_cyc_e nxt);
    cyc_vec_t v;
    v = '0;
    case (nxt)
      NX_FI:   v[CYC_FI]  = 1'b1;
      NX_DST:  v[CYC_DST] = 1'b1;
      NX_SRC:  v[CYC_SRC] = 1'b1;
      NX_EXC:  v[CYC_EXC] = 1'b1;
      NX_INT:  v[CYC_INT] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cyc_next_sel.sv
// Combinational next-cycle selector: picks the machine cycle that follows the
// current one from operand needs, interrupt state and halt.
module cyc_next_sel
  import cpu_cycle_pkg::*;
(
  input  cyc_vec_t cyc_i,
  input  sel_ctl_t ctl_i,
  output nxt_cyc_e nxt_c,
  output cyc_vec_t set_c
);

  always_comb begin
    nxt_c = NX_FI;
    if (cyc_i[CYC_FI]) begin
      if (ctl_i.need_src)      nxt_c = NX_SRC;
      else if (ctl_i.need_dst) nxt_c = NX_DST;
      else                     nxt_c = NX_EXC;
    end else if (cyc_i[CYC_SRC]) begin
      nxt_c = ctl_i.need_dst ? NX_DST : NX_EXC;
    end else if (cyc_i[CYC_DST]) begin
      nxt_c = NX_EXC;
    end else if (cyc_i[CYC_EXC]) begin
      // Interrupt outranks halt at the end of execute.
      if (ctl_i.int_req && ctl_i.int_en) nxt_c = NX_INT;
      else if (ctl_i.halt)               nxt_c = NX_HALT;
      else                               nxt_c = NX_FI;
    end
  end

  assign set_c = cyc_set_vec(nxt_c);

endmodule

// File: rtl/cycle_step_ctrl.sv
// Beat sequencer feeding the CPU cycle register's Set_* inputs.
// Optional watchdog on wait_req stalls: define CYC_WATCHDOG_EN.
module cycle_step_ctrl
  import cpu_cycle_pkg::*;
#(
  parameter int unsigned STEPS_FI  = DEF_STEPS_FI,
  parameter int unsigned STEPS_SRC = DEF_STEPS_SRC,
  parameter int unsigned STEPS_DST = DEF_STEPS_DST,
  parameter int unsigned STEPS_EXC = DEF_STEPS_EXC,
  parameter int unsigned STEPS_INT = DEF_STEPS_INT,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned WD_LIMIT  = DEF_WD_LIMIT
)(
  input  logic             clk,
  input  logic             Reset,
  input  logic             FI,
  input  logic             DST,
  input  logic             SRC,
  input  logic             EXC,
  input  logic             INT,
  input  logic             need_src,
  input  logic             need_dst,
  input  logic             int_req,
  input  logic             int_en,
  input  logic             halt,
  input  logic             run,
  input  logic             wait_req,
  output logic             Set_FI,
  output logic             Set_SRC,
  output logic             Set_DST,
  output logic             Set_EXC,
  output logic             Set_INT,
  output logic [CNT_W-1:0] step,
  output logic             last_step,
  output logic             halted,
  output logic             cyc_err,
  output logic             bus_err
);

  localparam int unsigned SC_W = CNT_W + 1;

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  cyc_vec_t         set_q, set_d;
  logic             cyc_err_q, cyc_err_d;

  cyc_vec_t         cyc_v;
  sel_ctl_t         ctl;
  nxt_cyc_e         nxt_c;
  cyc_vec_t         sel_set_c;
  logic [SC_W-1:0]  steps_cur_c;
  logic [CNT_W-1:0] last_idx_c;
  logic             wd_fire_c;

  always_comb begin
    cyc_v          = '0;
    cyc_v[CYC_FI]  = FI;
    cyc_v[CYC_DST] = DST;
    cyc_v[CYC_SRC] = SRC;
    cyc_v[CYC_EXC] = EXC;
    cyc_v[CYC_INT] = INT;
  end

  assign ctl = '{need_src: need_src, need_dst: need_dst, int_req: int_req,
                 int_en: int_en, halt: halt};

  cyc_next_sel u_sel (
    .cyc_i (cyc_v),
    .ctl_i (ctl),
    .nxt_c (nxt_c),
    .set_c (sel_set_c)
  );

  // Beat count of the current cycle; an illegal vector falls back to FI.
  always_comb begin
    steps_cur_c = SC_W'(STEPS_FI);
    if (cyc_v[CYC_DST])      steps_cur_c = SC_W'(STEPS_DST);
    else if (cyc_v[CYC_SRC]) steps_cur_c = SC_W'(STEPS_SRC);
    else if (cyc_v[CYC_EXC]) steps_cur_c = SC_W'(STEPS_EXC);
    else if (cyc_v[CYC_INT]) steps_cur_c = SC_W'(STEPS_INT);
  end

  assign last_idx_c = CNT_W'(steps_cur_c - SC_W'(1));

`ifdef CYC_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            bus_err_q, bus_err_d;

  always_comb begin
    wd_fire_c = wait_req && (wd_cnt_q == WD_W'(WD_LIMIT - 1));
    wd_cnt_d  = (wait_req && !wd_fire_c) ? wd_cnt_q + WD_W'(1) : '0;
    bus_err_d = wd_fire_c;
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      wd_cnt_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  localparam int unsigned wd_limit_unused = WD_LIMIT;

  assign wd_fire_c = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // Cycle inputs are only trusted outside the clk carrying a Set_* pulse.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    set_d     = '0;
    cyc_err_d = cyc_err_q;
    if (wd_fire_c) begin
      step_d  = '0;
      set_d   = cyc_set_vec(NX_INT);
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_HALT: begin
          step_d = '0;
          if (int_req && int_en) begin
            set_d   = cyc_set_vec(NX_INT);
            state_d = ST_RUN;
          end else if (run) begin
            set_d   = cyc_set_vec(NX_FI);
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if ((set_q == '0) && !$onehot(cyc_v)) begin
            set_d     = cyc_set_vec(NX_FI);
            step_d    = '0;
            cyc_err_d = 1'b1;
          end else if (!wait_req) begin
            if (step_q < last_idx_c) begin
              step_d = step_q + CNT_W'(1);
            end else begin
              step_d = '0;
              if (nxt_c == NX_HALT) state_d = ST_HALT;
              else                  set_d   = sel_set_c;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q   <= ST_RUN;
      step_q    <= '0;
      set_q     <= '0;
      cyc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      set_q     <= set_d;
      cyc_err_q <= cyc_err_d;
    end
  end

  assign Set_FI    = set_q[CYC_FI];
  assign Set_DST   = set_q[CYC_DST];
  assign Set_SRC   = set_q[CYC_SRC];
  assign Set_EXC   = set_q[CYC_EXC];
  assign Set_INT   = set_q[CYC_INT];
  assign step      = step_q;
  assign halted    = (state_q == ST_HALT);
  assign cyc_err   = cyc_err_q;
  assign last_step = (step_q == last_idx_c) && (state_q != ST_HALT);

endmodule
